// File: rtl/pipe_ctrl.sv
// Central sequencer for a 5-stage pipeline: stage update enables, bubble/kill
// controls, load-use / redirect / memory-wait handling and ebreak drain-to-halt.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ifu_valid,
  input  logic             need_rs1,
  input  logic             need_rs2,
  input  logic [4:0]       index_rs1,
  input  logic [4:0]       index_rs2,
  input  logic             idu_valid,
  input  logic [4:0]       idu_index_rd,
  input  logic             idu_load_en,
  input  logic             idu_ebreak_en,
  input  logic             exu_redirect,
  input  logic             lsu_busy,
  output logic             ifu_update,
  output logic             ifu_flush,
  output logic             idu_update,
  output logic             hazard_nop,
  output logic             flush_nop,
  output logic             exu_update,
  output logic             mmu_update,
  output logic             update,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {BOOT, RUN, FREEZE, DRAIN, HALT} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state, next_state;
  logic [DW-1:0] drain_cnt;
  logic          drain_load, drain_dec;
  logic          lu;

  assign lu = idu_valid & idu_load_en & (idu_index_rd != 5'd0) & ifu_valid &
              ((need_rs1 & (idu_index_rd == index_rs1)) |
               (need_rs2 & (idu_index_rd == index_rs2)));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    ifu_update = 1'b0;
    ifu_flush  = 1'b0;
    idu_update = 1'b0;
    hazard_nop = 1'b0;
    flush_nop  = 1'b0;
    exu_update = 1'b0;
    mmu_update = 1'b0;
    update     = 1'b0;
    halted     = 1'b0;
    unique case (state)
      BOOT: next_state = RUN;
      // FREEZE is RUN with lsu_busy held high; once it drops the same rules apply.
      RUN, FREEZE: begin
        if (lsu_busy) begin
          next_state = FREEZE;
        end else begin
          next_state = RUN;
          idu_update = 1'b1;
          exu_update = 1'b1;
          mmu_update = 1'b1;
          update     = 1'b1;
          if (exu_redirect) begin
            ifu_update = 1'b1;
            ifu_flush  = 1'b1;
            flush_nop  = 1'b1;
          end else if (idu_valid && idu_ebreak_en) begin
            flush_nop  = 1'b1;
            drain_load = 1'b1;
            next_state = DRAIN;
          end else if (lu) begin
            hazard_nop = 1'b1;
          end else begin
            ifu_update = 1'b1;
          end
        end
      end
      // Younger instructions are already squashed, so a redirect here is ignored.
      DRAIN: begin
        if (!lsu_busy) begin
          idu_update = 1'b1;
          flush_nop  = 1'b1;
          exu_update = 1'b1;
          mmu_update = 1'b1;
          update     = 1'b1;
          if (drain_cnt == '0) next_state = HALT;
          else                 drain_dec  = 1'b1;
        end
      end
      HALT:    halted     = 1'b1;
      default: next_state = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= BOOT;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      if (drain_load)     drain_cnt <= DW'(DRAIN_CYCLES - 1);
      else if (drain_dec) drain_cnt <= drain_cnt - 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc;

  assign stall_inc = ((state == RUN) || (state == FREEZE)) && !ifu_update;

  // ifu_flush is only ever raised by a taken redirect, so it marks flush events.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (ifu_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of single-cycle RUN vectors plus
// hand-written reset, freeze, ebreak-drain and reset-in-drain sequences.
module tb_pipe_ctrl;

  localparam int CNT_W = 32;

  // Output packing: ifu_update ifu_flush idu_update hazard_nop flush_nop exu mmu update halted
  localparam logic [8:0] O_NORM  = 9'b101001110;
  localparam logic [8:0] O_ZERO  = 9'b000000000;
  localparam logic [8:0] O_REDIR = 9'b111011110;
  localparam logic [8:0] O_DRAIN = 9'b001011110;
  localparam logic [8:0] O_LU    = 9'b001101110;
  localparam logic [8:0] O_HALT  = 9'b000000001;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ifu_valid, need_rs1, need_rs2, idu_valid, idu_load_en, idu_ebreak_en;
  logic exu_redirect, lsu_busy;
  logic [4:0] index_rs1, index_rs2, idu_index_rd;
  logic ifu_update, ifu_flush, idu_update, hazard_nop, flush_nop;
  logic exu_update, mmu_update, update, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_valid(ifu_valid), .need_rs1(need_rs1), .need_rs2(need_rs2),
    .index_rs1(index_rs1), .index_rs2(index_rs2),
    .idu_valid(idu_valid), .idu_index_rd(idu_index_rd),
    .idu_load_en(idu_load_en), .idu_ebreak_en(idu_ebreak_en),
    .exu_redirect(exu_redirect), .lsu_busy(lsu_busy),
    .ifu_update(ifu_update), .ifu_flush(ifu_flush), .idu_update(idu_update),
    .hazard_nop(hazard_nop), .flush_nop(flush_nop), .exu_update(exu_update),
    .mmu_update(mmu_update), .update(update), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ifu_valid, need_rs1, need_rs2;
    logic [4:0] rs1, rs2;
    logic       idu_valid;
    logic [4:0] rd;
    logic       load, redirect;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] outs();
    return {ifu_update, ifu_flush, idu_update, hazard_nop, flush_nop,
            exu_update, mmu_update, update, halted};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    ifu_valid = 1'b1; need_rs1 = 1'b0; need_rs2 = 1'b0;
    index_rs1 = 5'd0; index_rs2 = 5'd0;
    idu_valid = 1'b1; idu_index_rd = 5'd0; idu_load_en = 1'b0;
    idu_ebreak_en = 1'b0; exu_redirect = 1'b0; lsu_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string name, input int st, input int fl);
`ifdef PIPE_CTRL_PERF_EN
    check({name, "_stall"}, stall_cnt, st);
    check({name, "_flush"}, flush_cnt, fl);
`else
    check({name, "_stall"}, stall_cnt, 0);
    check({name, "_flush"}, flush_cnt, 0);
`endif
  endtask

  task automatic load_use();
    idle();
    idu_load_en = 1'b1; idu_index_rd = 5'd5; need_rs1 = 1'b1; index_rs1 = 5'd5;
  endtask

  initial begin
    //        name          ifv nr1 nr2 rs1 rs2 idv rd  ld  rdr  exp
    vecs.push_back('{"lu_rs1",      1, 1, 0, 5'd5,  5'd0, 1, 5'd5,  1, 0, O_LU});
    vecs.push_back('{"lu_rd0",      1, 1, 0, 5'd0,  5'd0, 1, 5'd0,  1, 0, O_NORM});
    vecs.push_back('{"redir_lu",    1, 1, 0, 5'd5,  5'd0, 1, 5'd5,  1, 1, O_REDIR});
    vecs.push_back('{"lu_rs2",      1, 0, 1, 5'd0,  5'd7, 1, 5'd7,  1, 0, O_LU});
    vecs.push_back('{"rs2_unused",  1, 0, 0, 5'd0,  5'd7, 1, 5'd7,  1, 0, O_NORM});
    vecs.push_back('{"idu_invalid", 1, 1, 0, 5'd5,  5'd0, 0, 5'd5,  1, 0, O_NORM});
    vecs.push_back('{"ifu_invalid", 0, 1, 0, 5'd5,  5'd0, 1, 5'd5,  1, 0, O_NORM});
    vecs.push_back('{"not_load",    1, 1, 0, 5'd5,  5'd0, 1, 5'd5,  0, 0, O_NORM});
    vecs.push_back('{"lu_x31",      1, 1, 0, 5'd31, 5'd0, 1, 5'd31, 1, 0, O_LU});
    vecs.push_back('{"redir_plain", 1, 0, 0, 5'd0,  5'd0, 1, 5'd3,  0, 1, O_REDIR});
    vecs.push_back('{"rd_mismatch", 1, 1, 1, 5'd6,  5'd4, 1, 5'd5,  1, 0, O_NORM});

    // Reset and boot
    idle();
    #3;
    check("reset_outs", outs(), O_ZERO);
    check_cnts("reset", 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("boot_outs", outs(), O_ZERO);
    tick();
    check("run_after_boot", outs(), O_NORM);

    // Single-cycle vectors in RUN: 3 load-use stalls, 2 redirects
    foreach (vecs[i]) begin
      ifu_valid = vecs[i].ifu_valid; need_rs1 = vecs[i].need_rs1;
      need_rs2 = vecs[i].need_rs2; index_rs1 = vecs[i].rs1; index_rs2 = vecs[i].rs2;
      idu_valid = vecs[i].idu_valid; idu_index_rd = vecs[i].rd;
      idu_load_en = vecs[i].load; exu_redirect = vecs[i].redirect;
      idu_ebreak_en = 1'b0; lsu_busy = 1'b0;
      #1;
      check(vecs[i].name, outs(), vecs[i].exp);
      tick();
    end

    // Load-use pair: one bubble, then the load has moved on
    load_use();
    #1;
    check("lu_seq_stall", outs(), O_LU);
    tick();
    idle();
    idu_valid = 1'b0; need_rs1 = 1'b1; index_rs1 = 5'd5;
    #1;
    check("lu_seq_resume", outs(), O_NORM);
    tick();

    // Memory wait for 4 cycles with a load-use pattern held underneath
    load_use();
    lsu_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("busy_%0d", c), outs(), O_ZERO);
      tick();
    end
    idle();
    #1;
    check("busy_release", outs(), O_NORM);
    tick();
    check_cnts("after_busy", 8, 2);

    // ebreak: 3 drain cycles with one memory-wait cycle in between, then halt
    idu_ebreak_en = 1'b1;
    #1;
    check("ebreak", outs(), O_DRAIN);
    tick();
    idle();
    exu_redirect = 1'b1;
    #1;
    check("drain_1", outs(), O_DRAIN);
    tick();
    lsu_busy = 1'b1;
    #1;
    check("drain_busy", outs(), O_ZERO);
    tick();
    lsu_busy = 1'b0;
    #1;
    check("drain_2", outs(), O_DRAIN);
    tick();
    #1;
    check("drain_3", outs(), O_DRAIN);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("halt_%0d", c), outs(), O_HALT);
      tick();
    end
    check_cnts("halt", 9, 2);

    // Reset out of HALT, then ebreak again and reset mid-drain
    rstn = 1'b0;
    #1;
    check("reset_halt", outs(), O_ZERO);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    #1;
    check("run_after_halt", outs(), O_NORM);
    idu_ebreak_en = 1'b1;
    #1;
    check("ebreak_again", outs(), O_DRAIN);
    tick();
    idle();
    #1;
    check("drain_again", outs(), O_DRAIN);
    #2;
    rstn = 1'b0;
    #1;
    check("reset_drain", outs(), O_ZERO);
    check_cnts("reset_drain", 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("boot_again", outs(), O_ZERO);
    tick();
    check("run_again", outs(), O_NORM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
